// File: rtl/breakout_pkg.sv
// Shared BCD constants and helpers for the Breakout score and display logic.
package breakout_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned MAX_DIG = 8;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // All-nines packed BCD pattern for the low 'digits' digits of an 8-digit field.
  function automatic logic [MAX_DIG*BCD_W-1:0] bcd_nines(input int unsigned digits);
    logic [MAX_DIG*BCD_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_DIG; i++) begin
      if (i < digits) r[i*BCD_W +: BCD_W] = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of the score adder: digit + addend + carry-in with decimal correction.
module bcd_digit_add
  import breakout_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic [BCD_W-1:0] addend,
  input  logic             cin,
  output logic [BCD_W-1:0] sum,
  output logic             cout
);

  localparam int unsigned RAW_W = BCD_W + 1;
  localparam logic [RAW_W-1:0] TEN = RAW_W'(10);

  logic [RAW_W-1:0] raw;

  always_comb begin
    raw  = {1'b0, d} + {1'b0, addend} + {{BCD_W{1'b0}}, cin};
    sum  = raw[BCD_W-1:0];
    cout = 1'b0;
    if (raw > {1'b0, BCD_MAX}) begin
      sum  = BCD_W'(raw - TEN);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_score_keeper.sv
// N-digit packed-BCD score accumulator with overflow policy and session high score.
module bcd_score_keeper
  import breakout_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                add_valid,
  input  logic [3:0]          add_amt,
  output logic [4*DIGITS-1:0] score,
  output logic [4*DIGITS-1:0] hi_score,
  output logic                new_hi,
  output logic                ovf
);

  localparam int unsigned SW = BCD_W * DIGITS;
  localparam logic [SW-1:0] NINES = SW'(bcd_nines(DIGITS));

  logic [SW-1:0]    score_q, score_d;
  logic [SW-1:0]    hi_q, hi_d;
  logic             new_hi_q, new_hi_d;
  logic             ovf_q, ovf_d;
  logic [BCD_W-1:0] amt_c;
  logic [SW-1:0]    sum_c;
  logic [DIGITS:0]  carry;
  logic             gt_c;
  logic             decided;

  assign amt_c    = (add_amt > BCD_MAX) ? BCD_MAX : add_amt;
  assign carry[0] = 1'b0;

  // Combinational ripple: only digit 0 sees the addend, the rest add carry only.
  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_digit_add u_add (
      .d      (score_q[g*BCD_W +: BCD_W]),
      .addend ((g == 0) ? amt_c : {BCD_W{1'b0}}),
      .cin    (carry[g]),
      .sum    (sum_c[g*BCD_W +: BCD_W]),
      .cout   (carry[g+1])
    );
  end

  // BCD magnitude compare, most significant digit first.
  always_comb begin
    gt_c    = 1'b0;
    decided = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      if (!decided && (score_q[i*BCD_W +: BCD_W] != hi_q[i*BCD_W +: BCD_W])) begin
        decided = 1'b1;
        gt_c    = score_q[i*BCD_W +: BCD_W] > hi_q[i*BCD_W +: BCD_W];
      end
    end
  end

  always_comb begin
    score_d  = score_q;
    ovf_d    = ovf_q;
    hi_d     = hi_q;
    new_hi_d = gt_c;
    if (gt_c) hi_d = score_q;
    if (clr) begin
      score_d = '0;
      ovf_d   = 1'b0;
    end else if (add_valid) begin
      score_d = sum_c;
      if (carry[DIGITS]) begin
        ovf_d = 1'b1;
        if (SATURATE) score_d = NINES;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      score_q  <= '0;
      hi_q     <= '0;
      new_hi_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      score_q  <= score_d;
      hi_q     <= hi_d;
      new_hi_q <= new_hi_d;
      ovf_q    <= ovf_d;
    end
  end

  assign score    = score_q;
  assign hi_score = hi_q;
  assign new_hi   = new_hi_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_bcd_score_keeper.sv
// Drives a saturating and a wrapping score keeper in lock-step against an integer model.
module tb_bcd_score_keeper;

  logic        clk = 1'b0;
  logic        rst, clr, add_valid;
  logic [3:0]  add_amt;
  logic [15:0] score_s, hi_s, score_w, hi_w;
  logic        nh_s, ovf_s, nh_w, ovf_w;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .add_valid(add_valid), .add_amt(add_amt),
    .score(score_s), .hi_score(hi_s), .new_hi(nh_s), .ovf(ovf_s)
  );

  bcd_score_keeper #(.DIGITS(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .clr(clr), .add_valid(add_valid), .add_amt(add_amt),
    .score(score_w), .hi_score(hi_w), .new_hi(nh_w), .ovf(ovf_w)
  );

  typedef struct packed {
    logic [15:0] s_score, s_hi, w_score, w_hi;
    logic        s_nh, s_ovf, w_nh, w_ovf;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  // Model state, index 0 = saturating, 1 = wrapping; plain binary integers.
  int m_score[2];
  int m_hi[2];
  bit m_nh[2];
  bit m_ovf[2];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_score[d] = 0; m_hi[d] = 0; m_nh[d] = 1'b0; m_ovf[d] = 1'b0;
    end
  endfunction

  function automatic void model_edge(input logic c, input logic v, input logic [3:0] a);
    int amt;
    int t;
    amt = (a > 4'd9) ? 9 : int'(a);
    for (int d = 0; d < 2; d++) begin
      m_nh[d] = m_score[d] > m_hi[d];
      if (m_nh[d]) m_hi[d] = m_score[d];
      if (c) begin
        m_score[d] = 0;
        m_ovf[d]   = 1'b0;
      end else if (v) begin
        t = m_score[d] + amt;
        if (t > 9999) begin
          m_ovf[d]   = 1'b1;
          m_score[d] = (d == 0) ? 9999 : t - 10000;
        end else begin
          m_score[d] = t;
        end
      end
    end
  endfunction

  // Drive one cycle of stimulus, push the model's prediction, sample after the edge.
  task automatic step(input logic c, input logic v, input logic [3:0] a);
    clr = c; add_valid = v; add_amt = a;
    model_edge(c, v, a);
    sb.push_back(exp_t'{s_score: to_bcd(m_score[0]), s_hi: to_bcd(m_hi[0]),
                        w_score: to_bcd(m_score[1]), w_hi: to_bcd(m_hi[1]),
                        s_nh: m_nh[0], s_ovf: m_ovf[0], w_nh: m_nh[1], w_ovf: m_ovf[1]});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; add_valid = 1'b0; add_amt = 4'd0;
    model_reset();
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({score_s, hi_s, nh_s, ovf_s} !== 34'd0) begin
      n_fail++; $display("FAIL reset_sat got %h want 0", {score_s, hi_s, nh_s, ovf_s});
    end
    n_checks++;
    if ({score_w, hi_w, nh_w, ovf_w} !== 34'd0) begin
      n_fail++; $display("FAIL reset_wrap got %h want 0", {score_w, hi_w, nh_w, ovf_w});
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_adds();
    logic [3:0] amts [4];
    bit         vld  [4];
    amts = '{4'd7, 4'd5, 4'd0, 4'd0};
    vld  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1'b0, vld[i], amts[i]);
      e = sb.pop_front();
      n_checks++;
      if (score_s !== e.s_score) begin
        n_fail++; $display("FAIL single_score[%0d] got %h want %h", i, score_s, e.s_score);
      end
      n_checks++;
      if ({nh_s, hi_s} !== {e.s_nh, e.s_hi}) begin
        n_fail++; $display("FAIL single_hi[%0d] got %b/%h want %b/%h", i, nh_s, hi_s, e.s_nh, e.s_hi);
      end
      n_checks++;
      if ({score_w, nh_w} !== {e.w_score, e.w_nh}) begin
        n_fail++; $display("FAIL single_wrap[%0d] got %h/%b want %h/%b", i, score_w, nh_w, e.w_score, e.w_nh);
      end
    end
    n_checks++;
    if ({score_s, hi_s} !== {16'h0012, 16'h0012}) begin
      n_fail++; $display("FAIL single_final got %h/%h want 0012/0012", score_s, hi_s);
    end
  endtask

  task automatic test_carry();
    step(1'b1, 1'b0, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if (score_s !== e.s_score) begin
      n_fail++; $display("FAIL carry_clr got %h want %h", score_s, e.s_score);
    end
    for (int i = 0; i < 111; i++) begin
      step(1'b0, 1'b1, 4'd9);
      e = sb.pop_front();
      n_checks++;
      if ({score_s, score_w} !== {e.s_score, e.w_score}) begin
        n_fail++; $display("FAIL carry_preload[%0d] got %h/%h want %h/%h", i, score_s, score_w, e.s_score, e.w_score);
      end
    end
    step(1'b0, 1'b1, 4'd1);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, ovf_s, score_w, ovf_w} !== {16'h1000, 1'b0, 16'h1000, 1'b0}) begin
      n_fail++; $display("FAIL carry_1000 got %h/%b %h/%b want 1000/0", score_s, ovf_s, score_w, ovf_w);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 1000; i++) begin
      step(1'b0, 1'b1, (i == 999) ? 4'd4 : 4'd9);
      e = sb.pop_front();
      n_checks++;
      if ({score_s, score_w} !== {e.s_score, e.w_score}) begin
        n_fail++; $display("FAIL ovf_preload[%0d] got %h/%h want %h/%h", i, score_s, score_w, e.s_score, e.w_score);
      end
    end
    n_checks++;
    if ({score_s, score_w} !== {16'h9995, 16'h9995}) begin
      n_fail++; $display("FAIL ovf_9995 got %h/%h want 9995", score_s, score_w);
    end
    step(1'b0, 1'b1, 4'd9);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, ovf_s} !== {16'h9999, 1'b1}) begin
      n_fail++; $display("FAIL ovf_sat got %h/%b want 9999/1", score_s, ovf_s);
    end
    n_checks++;
    if ({score_w, ovf_w} !== {16'h0004, 1'b1}) begin
      n_fail++; $display("FAIL ovf_wrap got %h/%b want 0004/1", score_w, ovf_w);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 4'd3);
      e = sb.pop_front();
      n_checks++;
      if ({score_s, ovf_s} !== {16'h9999, 1'b1}) begin
        n_fail++; $display("FAIL sat_hold[%0d] got %h/%b want 9999/1", i, score_s, ovf_s);
      end
      n_checks++;
      if ({nh_s, hi_s} !== {e.s_nh, e.s_hi}) begin
        n_fail++; $display("FAIL sat_hi[%0d] got %b/%h want %b/%h", i, nh_s, hi_s, e.s_nh, e.s_hi);
      end
      n_checks++;
      if ({nh_w, hi_w, score_w, ovf_w} !== {1'b0, 16'h9995, e.w_score, 1'b1}) begin
        n_fail++; $display("FAIL wrap_hi[%0d] got %b/%h/%h/%b want 0/9995/%h/1", i, nh_w, hi_w, score_w, ovf_w, e.w_score);
      end
    end
  endtask

  task automatic test_clear_vs_add();
    logic [3:0] amts [5];
    rst = 1'b0;
    model_reset();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    amts = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd4};
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, amts[i]);
      e = sb.pop_front();
    end
    step(1'b0, 1'b0, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, hi_s, score_w, hi_w} !== {4{16'h0040}}) begin
      n_fail++; $display("FAIL clr_setup got %h/%h %h/%h want 0040", score_s, hi_s, score_w, hi_w);
    end
    step(1'b1, 1'b1, 4'd6);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, ovf_s, hi_s} !== {16'h0000, 1'b0, 16'h0040}) begin
      n_fail++; $display("FAIL clr_wins got %h/%b/%h want 0000/0/0040", score_s, ovf_s, hi_s);
    end
    step(1'b0, 1'b1, 4'hF);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, score_w, nh_s} !== {16'h0009, 16'h0009, 1'b0}) begin
      n_fail++; $display("FAIL clamp got %h/%h/%b want 0009/0009/0", score_s, score_w, nh_s);
    end
    step(1'b0, 1'b1, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, hi_s, nh_s} !== {e.s_score, e.s_hi, e.s_nh}) begin
      n_fail++; $display("FAIL add_zero got %h/%h/%b want %h/%h/%b", score_s, hi_s, nh_s, e.s_score, e.s_hi, e.s_nh);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 4'd3);
    e = sb.pop_front();
    step(1'b0, 1'b1, 4'd4);
    e = sb.pop_front();
    n_checks++;
    if (score_s !== e.s_score) begin
      n_fail++; $display("FAIL async_pre got %h want %h", score_s, e.s_score);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({score_s, hi_s, nh_s, ovf_s, score_w, hi_w, nh_w, ovf_w} !== 68'd0) begin
      n_fail++; $display("FAIL async_now got %h/%h want 0", score_s, hi_s);
    end
    model_reset();
    sb.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if ({score_s, hi_s, nh_s, ovf_s} !== 34'd0) begin
      n_fail++; $display("FAIL async_hold got %h/%h want 0", score_s, hi_s);
    end
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 1'b1, 4'd5);
    e = sb.pop_front();
    n_checks++;
    if ({score_s, score_w} !== {16'h0005, e.w_score}) begin
      n_fail++; $display("FAIL async_first_add got %h/%h want 0005/%h", score_s, score_w, e.w_score);
    end
    step(1'b0, 1'b0, 4'd0);
    e = sb.pop_front();
    n_checks++;
    if ({nh_s, hi_s} !== {1'b1, 16'h0005}) begin
      n_fail++; $display("FAIL async_hi got %b/%h want 1/0005", nh_s, hi_s);
    end
  endtask

  initial begin
    test_reset();
    test_single_adds();
    test_carry();
    test_overflow();
    test_clear_vs_add();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_score_keeper.md
# bcd_score_keeper

Parametrised, fully synchronous BCD score counter for the Breakout game. Accepts weighted point additions from game logic and accumulates them into an N-digit packed-BCD score with a configurable overflow policy. Tracks a session high score that survives game clears. Replaces the ripple-clocked 4-digit score chain; every flop runs on the system clock, so the seven-segment display path samples a glitch-free value.

## Interface
- `DIGITS`, 4: number of BCD digits; legal range 1–8.
- `SATURATE`, 1: 1 = clamp at all-9s on overflow; 0 = wrap modulo 10^DIGITS.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-low reset; one clock domain only.
- `clr`  in  1: synchronous clear of the current score and overflow flag (new game).
- `add_valid`  in  1: an addition is requested this cycle.
- `add_amt`  in  4: points to add, binary 0–9; values 10–15 are clamped to 9.
- `score`  out  4*DIGITS: current score, packed BCD, digit 0 in bits [3:0].
- `hi_score`  out  4*DIGITS: highest score reached since reset, packed BCD.
- `new_hi`  out  1: one-cycle pulse when `hi_score` is updated.
- `ovf`  out  1: sticky flag; score has overflowed since the last clear or reset.

## Operation
- Reset (`rst`=0, asynchronous): `score`=0, `hi_score`=0, `new_hi`=0, `ovf`=0.
- Priority each cycle: `clr` > `add_valid`. When `clr`=1: `score`←0, `ovf`←0, any simultaneous add is discarded, and `hi_score` is untouched.
- Add: `add_amt` (clamped) enters digit 0 as an addend. Each higher digit adds only the incoming carry. Per-digit rule: sum = digit + addend + cin; if sum > 9, the digit becomes sum−10 and cout=1. The carry chain is combinational across all digits within one cycle.
- When digit DIGITS−1 produces a carry-out, overflow occurs and `ovf`←1:
  - `SATURATE`=1: `score`←all 9s (0x9999 for 4 digits).
  - `SATURATE`=0: `score`←wrapped sum.
- Adding 0 with `add_valid`=1 is legal and leaves `score` unchanged.
- While saturated, further adds leave `score` at all 9s and `ovf` stays 1.
- High-score tracking:
  - Registered compare: if `score` > `hi_score` (BCD magnitude compare, MSD first), then `hi_score`←`score` and `new_hi`=1 for that cycle; otherwise `new_hi`=0.
  - When the score wraps, `hi_score` keeps the pre-wrap maximum.
- Digit invariant: a digit above 9 is never stored in `score` or `hi_score`.

## Timing
- Add latency: an add sampled at edge k is visible on `score` after edge k. One add is accepted per cycle, back-to-back, with no stall or busy signal.
- `ovf` sets on the same edge as the overflowing `score` update.
- `hi_score` and `new_hi` lag `score` by one cycle (edge k+1). Consecutive increasing scores produce consecutive `new_hi` pulses.
- `clr` takes effect at the sampling edge. The compare in the following cycle sees `score`=0 and never pulses `new_hi`.
- An asynchronous `rst` in mid-stream aborts everything immediately. The first add after release lands on the first rising edge with `rst`=1.

## Structure
- Shared package `breakout_pkg`: `BCD_W`=4, `BCD_MAX`=4'd9, and the all-nines fill helper. The display decoder shares this package.
- One sub-module, `bcd_digit_add`: combinational, with inputs `d`[3:0], `addend`[3:0], `cin` and outputs `sum`[3:0], `cout`. The top module instantiates it DIGITS times in a generate loop.
- The top level holds the clamp logic, the score register, the overflow and saturation mux, the BCD magnitude comparator, and the `hi_score`/`new_hi` registers.

## Test plan
- Reset then single adds: DIGITS=4; add 7, then add 5 → `score`=0x0012. `new_hi` pulses after each update; final `hi_score`=0x0012.
- Multi-digit carry: preload to 0x0999 via adds, then add 1 → `score`=0x1000 on the next edge, `ovf`=0.
- Saturate mode: reach 0x9995, add 9 → `score`=0x9999, `ovf`=1. Add 3 more → unchanged.
- Wrap mode (`SATURATE`=0): reach 0x9995, add 9 → `score`=0x0004, `ovf`=1. `hi_score` stays 0x9995 and `new_hi` does not pulse.
- Clear vs add: `score`=0x0040 and `hi_score`=0x0040; assert `clr` and `add_valid` with `add_amt`=6 together → `score`=0, `ovf`=0, `hi_score`=0x0040. Then add 0xF → `score`=0x0009 (clamped).
- Async reset: assert `rst` low between clock edges during back-to-back adds → all outputs read 0 before the next edge; the first add after release counts normally.
